// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, constants and lane/extension helpers for the data memory LSU
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_MISALIGN = 2'd1;
  localparam logic [1:0] FC_RANGE    = 2'd2;
  localparam logic [1:0] FC_ILLEGAL  = 2'd3;

  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B:    lane_mask = 4'b0001 << off;
      F3_H:    lane_mask = off[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    load_ext = {{24{b[7]}}, b};
      F3_H:    load_ext = {{16{h[15]}}, h};
      F3_W:    load_ext = word;
      F3_BU:   load_ext = {24'd0, b};
      F3_HU:   load_ext = {16'd0, h};
      default: load_ext = '0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// rtl/dmem_bank.sv - word array with byte write enables and one registered read port
module dmem_bank #(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = 8
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [3:0]       wr_be,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    // Read word is held until the next accept, so it stays valid across WAIT.
    if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - single-outstanding load/store unit in front of a byte-lane data memory
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 32,
  parameter int READ_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic [1:0]        rsp_fault_code
);

  localparam int          IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [2:0]  LAT_LAST = 3'(READ_LAT - 1);

  state_e      state_q, state_d, accept_next;
  logic [2:0]  lat_cnt_q;
  logic        accept;
  logic        illegal, misaligned, out_of_range;
  logic [1:0]  code_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [1:0]  code_q;
  logic [31:0] wdata_lanes;
  logic [31:0] bank_rdata;

  assign accept = req_valid & req_ready;

  always_comb begin
    illegal = 1'b0;
    case (req_funct3)
      F3_B, F3_H, F3_W: illegal = 1'b0;
      F3_BU, F3_HU:     illegal = req_we;
      default:          illegal = 1'b1;
    endcase
    misaligned   = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                   (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    out_of_range = (req_addr >> (IDX_W + 2)) != '0;
    code_d       = illegal ? FC_ILLEGAL : misaligned ? FC_MISALIGN :
                   out_of_range ? FC_RANGE : FC_NONE;
  end

  always_comb begin
    wdata_lanes = req_wdata;
    case (req_funct3[1:0])
      2'b00:   wdata_lanes = {4{req_wdata[7:0]}};
      2'b01:   wdata_lanes = {2{req_wdata[15:0]}};
      default: wdata_lanes = req_wdata;
    endcase
  end

  always_comb begin
    accept_next = (code_d != FC_NONE || req_we || READ_LAT == 1) ? S_RESP : S_WAIT;
    state_d     = state_q;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = accept_next;
      end
      S_WAIT: begin
        if (lat_cnt_q == LAT_LAST) state_d = S_RESP;
      end
      S_RESP: begin
        req_ready = 1'b1;
        rsp_valid = 1'b1;
        state_d   = req_valid ? accept_next : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      lat_cnt_q <= '0;
      we_q      <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      code_q    <= FC_NONE;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q      <= req_we;
        f3_q      <= req_funct3;
        off_q     <= req_addr[1:0];
        code_q    <= code_d;
        // First WAIT cycle already counts as one cycle of latency.
        lat_cnt_q <= (accept_next == S_WAIT) ? 3'd1 : 3'd0;
      end else if (state_q == S_WAIT) begin
        lat_cnt_q <= (lat_cnt_q == LAT_LAST) ? 3'd0 : lat_cnt_q + 3'd1;
      end
    end
  end

  dmem_bank #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_bank (
    .clk    (clk),
    .wr_en  (accept & req_we & (code_d == FC_NONE) & rst_n),
    .wr_be  (lane_mask(req_funct3, req_addr[1:0])),
    .wr_idx (req_addr[IDX_W+1:2]),
    .wr_data(wdata_lanes),
    .rd_en  (accept & ~req_we & rst_n),
    .rd_idx (req_addr[IDX_W+1:2]),
    .rd_data(bank_rdata)
  );

  assign rsp_fault      = rsp_valid & (code_q != FC_NONE);
  assign rsp_fault_code = rsp_valid ? code_q : FC_NONE;
  assign rsp_rdata      = (rsp_valid && !we_q && code_q == FC_NONE) ?
                          load_ext(bank_rdata, f3_q, off_q) : 32'd0;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - self-checking bench for dmem_lsu at read latencies 1, 3 and 4
module tb_dmem_lsu;

  localparam int DEPTH = 256;

  typedef struct {
    int          k;
    int          cyc;
    logic [31:0] rdata;
    logic        fault;
    logic [1:0]  code;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n          [3];
  logic        req_valid      [3];
  logic        req_ready      [3];
  logic        req_we         [3];
  logic [2:0]  req_funct3     [3];
  logic [31:0] req_addr       [3];
  logic [31:0] req_wdata      [3];
  logic        rsp_valid      [3];
  logic [31:0] rsp_rdata      [3];
  logic        rsp_fault      [3];
  logic [1:0]  rsp_fault_code [3];

  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  bit          cmp_en = 1'b0;
  exp_t        expq[$];
  logic [7:0]  mb [3][DEPTH*4];
  logic [31:0] last_rdata   [3];
  logic [1:0]  last_code    [3];
  int          last_rsp_cyc [3];
  int          last_acc_cyc [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_lsu #(
      .DEPTH_WORDS(DEPTH),
      .ADDR_W     (32),
      .READ_LAT   (g == 0 ? 1 : (g == 1 ? 3 : 4))
    ) dut (
      .clk           (clk),
      .rst_n         (rst_n[g]),
      .req_valid     (req_valid[g]),
      .req_ready     (req_ready[g]),
      .req_we        (req_we[g]),
      .req_funct3    (req_funct3[g]),
      .req_addr      (req_addr[g]),
      .req_wdata     (req_wdata[g]),
      .rsp_valid     (rsp_valid[g]),
      .rsp_rdata     (rsp_rdata[g]),
      .rsp_fault     (rsp_fault[g]),
      .rsp_fault_code(rsp_fault_code[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pending(input int k);
    int n = 0;
    foreach (expq[i]) if (expq[i].k == k) n++;
    return n;
  endfunction

  // Response model: decides fault, memory effect and load value from the byte-level rules.
  task automatic model(input int k, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input bit track);
    int          sz;
    int          lat;
    bit          sgn;
    logic [1:0]  code;
    logic [31:0] v;
    exp_t        e;
    lat = (k == 0) ? 1 : (k == 1) ? 3 : 4;
    case (f3)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      default:    sz = 4;
    endcase
    sgn = (f3 == 3'd0) || (f3 == 3'd1);
    if (we ? (f3 > 3'd2) : !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5))
      code = 2'd3;
    else if (addr % sz != 0)
      code = 2'd1;
    else if (addr >= 32'(DEPTH * 4))
      code = 2'd2;
    else
      code = 2'd0;
    v = 32'd0;
    if (code == 2'd0) begin
      for (int i = 0; i < sz; i++) begin
        if (we) mb[k][int'(addr) + i] = wd[8*i +: 8];
        else    v[8*i +: 8] = mb[k][int'(addr) + i];
      end
      if (!we && sgn && v[8*sz-1]) begin
        for (int i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
      end
    end
    if (we) v = 32'd0;
    e.k     = k;
    e.cyc   = cyc + ((code == 2'd0 && !we) ? lat - 1 : 0);
    e.rdata = v;
    e.fault = (code != 2'd0);
    e.code  = code;
    if (track) expq.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the accept edge.
  task automatic issue(input int k, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input bit track = 1'b1);
    int g = 0;
    req_valid[k]  = 1'b1;
    req_we[k]     = we;
    req_funct3[k] = f3;
    req_addr[k]   = addr;
    req_wdata[k]  = wd;
    while (req_ready[k] !== 1'b1 && g < 20) begin
      @(posedge clk); #1; g++;
    end
    chk($sformatf("ready_wait[%0d]", k), 32'(g < 20), 32'd1);
    @(posedge clk); #1;
    last_acc_cyc[k] = cyc;
    model(k, we, f3, addr, wd, track);
    req_valid[k]  = 1'b0;
    req_we[k]     = ~we;
    req_funct3[k] = 3'd7;
    req_addr[k]   = ~addr;
    req_wdata[k]  = ~wd;
  endtask

  task automatic drain(input int k);
    int g = 0;
    while (pending(k) > 0 && g < 20) begin
      @(posedge clk); #1; g++;
    end
    chk($sformatf("drain_timeout[%0d]", k), 32'(pending(k)), 32'd0);
    for (int i = expq.size() - 1; i >= 0; i--) if (expq[i].k == k) expq.delete(i);
  endtask

  always @(negedge clk) begin
    int   hit;
    exp_t e;
    if (cmp_en) begin
      for (int k = 0; k < 3; k++) begin
        hit = -1;
        foreach (expq[i]) if (expq[i].k == k && expq[i].cyc == cyc) hit = i;
        if (hit >= 0) begin
          e = expq[hit];
          expq.delete(hit);
          chk($sformatf("rsp_valid[%0d]", k), 32'(rsp_valid[k]), 32'd1);
          chk($sformatf("rsp_rdata[%0d]", k), rsp_rdata[k], e.rdata);
          chk($sformatf("rsp_fault[%0d]", k), 32'(rsp_fault[k]), 32'(e.fault));
          chk($sformatf("rsp_fault_code[%0d]", k), 32'(rsp_fault_code[k]), 32'(e.code));
          last_rdata[k]   = rsp_rdata[k];
          last_code[k]    = rsp_fault_code[k];
          last_rsp_cyc[k] = cyc;
        end else begin
          chk($sformatf("rsp_quiet[%0d]", k),
              {rsp_valid[k], rsp_fault[k], rsp_fault_code[k], 28'd0} | rsp_rdata[k], 32'd0);
        end
      end
    end
  end

  initial begin
    int a;
    foreach (mb[k, i]) mb[k][i] = 8'h00;
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; req_valid[k] = 1'b0; req_we[k] = 1'b0;
      req_funct3[k] = 3'd0; req_addr[k] = 32'd0; req_wdata[k] = 32'd0;
      last_rdata[k] = 32'd0; last_code[k] = 2'd0; last_rsp_cyc[k] = 0; last_acc_cyc[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_ready[%0d]", k), 32'(req_ready[k]), 32'd1);
      chk($sformatf("reset_valid[%0d]", k), 32'(rsp_valid[k]), 32'd0);
      chk($sformatf("reset_rdata[%0d]", k), rsp_rdata[k], 32'd0);
      chk($sformatf("reset_fault[%0d]", k), 32'(rsp_fault[k]), 32'd0);
      chk($sformatf("reset_code[%0d]", k), 32'(rsp_fault_code[k]), 32'd0);
    end
    cmp_en = 1'b1;

    // READ_LAT=1: store then load after an idle cycle
    issue(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    drain(0);
    issue(0, 1'b0, 3'd2, 32'h10, 32'h0);
    drain(0);
    chk("lw_0x10", last_rdata[0], 32'hDEADBEEF);

    // byte lanes and extension
    issue(0, 1'b1, 3'd0, 32'h11, 32'hFFFFFF80);
    issue(0, 1'b1, 3'd1, 32'h12, 32'hABCD1234);
    issue(0, 1'b0, 3'd2, 32'h10, 32'h0);
    drain(0);
    chk("lanes_word", last_rdata[0], 32'h123480EF);
    issue(0, 1'b0, 3'd0, 32'h11, 32'h0);  drain(0);
    chk("lb_0x11", last_rdata[0], 32'hFFFFFF80);
    issue(0, 1'b0, 3'd4, 32'h11, 32'h0);  drain(0);
    chk("lbu_0x11", last_rdata[0], 32'h00000080);
    issue(0, 1'b0, 3'd1, 32'h12, 32'h0);  drain(0);
    chk("lh_0x12", last_rdata[0], 32'h00001234);
    issue(0, 1'b0, 3'd1, 32'h10, 32'h0);  drain(0);
    chk("lh_0x10", last_rdata[0], 32'hFFFF80EF);
    issue(0, 1'b0, 3'd5, 32'h10, 32'h0);  drain(0);
    chk("lhu_0x10", last_rdata[0], 32'h000080EF);

    // faults, back to back
    issue(0, 1'b0, 3'd2, 32'h02, 32'h0);
    issue(0, 1'b1, 3'd2, 32'(DEPTH * 4), 32'hFFFFFFFF);
    issue(0, 1'b0, 3'd3, 32'h10, 32'h0);
    drain(0);
    chk("fault_illegal_code", 32'(last_code[0]), 32'd3);
    issue(0, 1'b0, 3'd2, 32'h00, 32'h0);  drain(0);
    chk("oor_store_no_write", last_rdata[0], 32'h0);
    issue(0, 1'b1, 3'd1, 32'h13, 32'h1111);
    issue(0, 1'b1, 3'd4, 32'h10, 32'h2222);
    issue(0, 1'b0, 3'd3, 32'h403, 32'h0);
    issue(0, 1'b0, 3'd2, 32'h402, 32'h0);
    drain(0);
    chk("misalign_over_range", 32'(last_code[0]), 32'd1);
    issue(0, 1'b0, 3'd2, 32'h10, 32'h0);  drain(0);
    chk("faulted_stores_no_write", last_rdata[0], 32'h123480EF);

    // read-after-write with load in the store's response cycle
    issue(0, 1'b1, 3'd2, 32'h20, 32'hCAFEF00D);
    issue(0, 1'b0, 3'd2, 32'h20, 32'h0);
    drain(0);
    chk("raw_b2b", last_rdata[0], 32'hCAFEF00D);

    // READ_LAT=3 timing
    issue(1, 1'b1, 3'd2, 32'h40, 32'h000055AA);
    issue(1, 1'b0, 3'd2, 32'h40, 32'h0);
    a = last_acc_cyc[1];
    chk("lat3_ready_e1", 32'(req_ready[1]), 32'd0);
    @(posedge clk); #1;
    chk("lat3_ready_e2", 32'(req_ready[1]), 32'd0);
    @(posedge clk); #1;
    chk("lat3_ready_resp", 32'(req_ready[1]), 32'd1);
    issue(1, 1'b0, 3'd0, 32'h40, 32'h0);
    drain(1);
    chk("lat3_second_rsp_cycle", 32'(last_rsp_cyc[1]), 32'(a + 5));
    chk("lat3_lb", last_rdata[1], 32'hFFFFFFAA);
    issue(1, 1'b0, 3'd2, 32'h41, 32'h0);  drain(1);
    chk("lat3_fault_code", 32'(last_code[1]), 32'd1);

    // READ_LAT=4: reset discards an in-flight load
    issue(2, 1'b1, 3'd2, 32'h08, 32'hA5A5A5A5);
    drain(2);
    issue(2, 1'b0, 3'd2, 32'h08, 32'h0, 1'b0);
    @(posedge clk); #1;
    rst_n[2] = 1'b0;
    @(posedge clk); #1;
    rst_n[2] = 1'b1;
    chk("midreset_ready", 32'(req_ready[2]), 32'd1);
    repeat (6) @(posedge clk);
    #1;
    chk("midreset_ready_later", 32'(req_ready[2]), 32'd1);
    issue(2, 1'b0, 3'd2, 32'h08, 32'h0);  drain(2);
    chk("midreset_data_kept", last_rdata[2], 32'hA5A5A5A5);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
